pipe_front_regs: RTL and testbench
==================================

PIPE_FRONT_REGS -- requirements
Module: pipe_front_regs

Interface
REQ-001 SHALL have parameter XLEN, default 32: datapath width.
REQ-002 SHALL have parameter CTRL_W, default 12: width of the decoded control bundle.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value after reset.
REQ-004 SHALL have port i_clk  input  1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_rst  input  1: synchronous, active-high reset.
REQ-006 SHALL have ports i_pc_stall, i_if_id_stall, i_if_id_flush, i_id_ex_flush  input  1 each: hazard-control commands.
REQ-007 SHALL have port i_pc_next  input  XLEN: next fetch address (sequential or redirect, muxed upstream).
REQ-008 SHALL have port i_instr_f  input  32: instruction fetched at o_pc_f.
REQ-009 SHALL have ports i_rd1_d, i_rd2_d, i_imm_d  input  XLEN each: register-file reads and immediate in decode.
REQ-010 SHALL have port i_ctrl_d  input  CTRL_W: decoded control bundle; bit 0 = reg_write.
REQ-011 SHALL have port o_pc_f  output  XLEN: current PC register.
REQ-012 SHALL have ports o_instr_d  output  32, o_pc_d and o_pc_plus4_d  output  XLEN, o_valid_d  output  1: IF/ID register contents.
REQ-013 SHALL have ports o_rs1_d, o_rs2_d, o_rd_d  output  5 each: o_instr_d[19:15], [24:20], [11:7], combinational.
REQ-014 SHALL have ports o_pc_e, o_pc_plus4_e, o_rd1_e, o_rd2_e, o_imm_e  output  XLEN each: ID/EX data.
REQ-015 SHALL have ports o_rs1_e, o_rs2_e, o_rd_e  output  5 each, o_ctrl_e  output  CTRL_W, o_valid_e  output  1: ID/EX tags and control.
REQ-016 SHALL have ports o_stall_cnt, o_flush_cnt  output  16 each: performance counters.

Function
REQ-017 PC register: if i_pc_stall, SHALL hold; otherwise SHALL load i_pc_next every cycle.
REQ-018 IF/ID priority SHALL be flush > stall > load.
REQ-019 IF/ID load SHALL capture i_instr_f, o_pc_f, o_pc_f+4 (modulo 2^XLEN), and set o_valid_d=1.
REQ-020 IF/ID flush SHALL set o_instr_d=32'h0000_0013 (NOP), o_pc_d=0, o_pc_plus4_d=0, o_valid_d=0.
REQ-021 IF/ID stall SHALL hold all IF/ID fields unchanged, including o_valid_d.
REQ-022 ID/EX SHALL have no stall input; it SHALL load every cycle unless flushed.
REQ-023 ID/EX load SHALL capture o_pc_d, o_pc_plus4_d, i_rd1_d, i_rd2_d, i_imm_d, o_rs1_d, o_rs2_d, o_rd_d, i_ctrl_d and o_valid_d.
REQ-024 ID/EX flush (bubble) SHALL zero every ID/EX field, including o_ctrl_e, o_rd_e and o_valid_e.
REQ-025 When o_valid_d=0 and no flush, ID/EX SHALL load o_ctrl_e=0 regardless of i_ctrl_d, so that invalid slots never write back.
REQ-026 Simultaneous i_if_id_stall and i_id_ex_flush (load-use) SHALL hold IF/ID and PC, and insert one bubble in ID/EX in the same cycle.
REQ-027 Simultaneous i_if_id_flush and i_if_id_stall SHALL resolve to flush per REQ-018.
REQ-028 o_stall_cnt SHALL increment by 1 on each non-reset cycle with i_pc_stall=1, saturating at 16'hFFFF.
REQ-029 o_flush_cnt SHALL increment by 1 on each non-reset cycle with i_if_id_flush=1, saturating at 16'hFFFF.
REQ-030 Latency SHALL be one cycle per stage: an instruction present at i_instr_f in cycle n appears on o_instr_d in n+1, and its fields appear on ID/EX outputs in n+2 absent stall/flush.

Reset
REQ-031 i_rst=1 at a rising edge SHALL set o_pc_f=RESET_PC and override all stall/flush inputs.
REQ-032 i_rst=1 at a rising edge SHALL set the IF/ID register to the flush values of REQ-020.
REQ-033 i_rst=1 at a rising edge SHALL set the ID/EX register to all zeros and both counters to 0.
REQ-034 Reset asserted mid-stall or mid-flush SHALL take effect at that edge; the first edge after deassertion SHALL perform a normal load.

Verification
REQ-035 Reset, then a free run of 3 cycles -> o_pc_f sequence 0,4,8; o_instr_d=NOP with o_valid_d=0 on cycle 1, then o_valid_d=1.
REQ-036 Load-use: assert i_pc_stall, i_if_id_stall and i_id_ex_flush together for 1 cycle -> o_pc_f and o_instr_d unchanged, o_ctrl_e=0, o_rd_e=0, o_stall_cnt +1.
REQ-037 Branch taken: i_if_id_flush=1, i_id_ex_flush=1, i_pc_next=32'h100 -> next cycle o_pc_f=32'h100, o_instr_d=32'h0000_0013, o_valid_e=0, o_flush_cnt +1.
REQ-038 Assert i_if_id_flush and i_if_id_stall together -> IF/ID takes NOP, not the held value.
REQ-039 Hold i_pc_stall=1 for 70000 cycles -> o_stall_cnt=16'hFFFF and stays there.
REQ-040 Assert i_rst during an active stall -> next cycle o_pc_f=RESET_PC, all ID/EX outputs 0, both counters 0.

Source files
------------

// File: rtl/pipe_front_regs.sv
// Front-end pipeline registers: PC, IF/ID and ID/EX stages with hazard
// control (stall/flush) and saturating stall/flush performance counters.
// An invalid decode slot always enters execute with an all-zero control
// bundle, so a bubble can never cause a register write-back.
module pipe_front_regs #(
    parameter int              XLEN     = 32,
    parameter int              CTRL_W   = 12,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_pc_stall,
    input  logic              i_if_id_stall,
    input  logic              i_if_id_flush,
    input  logic              i_id_ex_flush,
    input  logic [XLEN-1:0]   i_pc_next,
    input  logic [31:0]       i_instr_f,
    input  logic [XLEN-1:0]   i_rd1_d,
    input  logic [XLEN-1:0]   i_rd2_d,
    input  logic [XLEN-1:0]   i_imm_d,
    input  logic [CTRL_W-1:0] i_ctrl_d,
    output logic [XLEN-1:0]   o_pc_f,
    output logic [31:0]       o_instr_d,
    output logic [XLEN-1:0]   o_pc_d,
    output logic [XLEN-1:0]   o_pc_plus4_d,
    output logic              o_valid_d,
    output logic [4:0]        o_rs1_d,
    output logic [4:0]        o_rs2_d,
    output logic [4:0]        o_rd_d,
    output logic [XLEN-1:0]   o_pc_e,
    output logic [XLEN-1:0]   o_pc_plus4_e,
    output logic [XLEN-1:0]   o_rd1_e,
    output logic [XLEN-1:0]   o_rd2_e,
    output logic [XLEN-1:0]   o_imm_e,
    output logic [4:0]        o_rs1_e,
    output logic [4:0]        o_rs2_e,
    output logic [4:0]        o_rd_e,
    output logic [CTRL_W-1:0] o_ctrl_e,
    output logic              o_valid_e,
    output logic [15:0]       o_stall_cnt,
    output logic [15:0]       o_flush_cnt
);

    localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(32'd4);

    // Saturating 16-bit increment used by both performance counters.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

    logic [XLEN-1:0]   pc_r;
    logic [31:0]       instr_d_r;
    logic [XLEN-1:0]   pc_d_r;
    logic [XLEN-1:0]   pc_plus4_d_r;
    logic              valid_d_r;
    logic [XLEN-1:0]   pc_e_r;
    logic [XLEN-1:0]   pc_plus4_e_r;
    logic [XLEN-1:0]   rd1_e_r;
    logic [XLEN-1:0]   rd2_e_r;
    logic [XLEN-1:0]   imm_e_r;
    logic [4:0]        rs1_e_r;
    logic [4:0]        rs2_e_r;
    logic [4:0]        rd_e_r;
    logic [CTRL_W-1:0] ctrl_e_r;
    logic              valid_e_r;
    logic [15:0]       stall_cnt_r;
    logic [15:0]       flush_cnt_r;
    logic [CTRL_W-1:0] ctrl_gated_s;
    logic [4:0]        rs1_d_s;
    logic [4:0]        rs2_d_s;
    logic [4:0]        rd_d_s;

    // Register-index fields decoded straight from the IF/ID instruction.
    always_comb begin
        rs1_d_s = instr_d_r[19:15];
        rs2_d_s = instr_d_r[24:20];
        rd_d_s  = instr_d_r[11:7];
    end

    // Kill the control bundle of an invalid decode slot before it enters EX.
    always_comb begin
        ctrl_gated_s = {CTRL_W{1'b0}};
        if (valid_d_r) begin
            ctrl_gated_s = i_ctrl_d;
        end else begin
            ctrl_gated_s = {CTRL_W{1'b0}};
        end
    end

    // PC register: hold on stall, otherwise take the upstream next address.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_r <= RESET_PC;
        end else if (!i_pc_stall) begin
            pc_r <= i_pc_next;
        end
    end

    // IF/ID register: reset/flush inject a NOP, stall holds, else load.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_if_id_flush) begin
            instr_d_r    <= NOP_INSTR;
            pc_d_r       <= {XLEN{1'b0}};
            pc_plus4_d_r <= {XLEN{1'b0}};
            valid_d_r    <= 1'b0;
        end else if (!i_if_id_stall) begin
            instr_d_r    <= i_instr_f;
            pc_d_r       <= pc_r;
            pc_plus4_d_r <= pc_r + PC_STEP;
            valid_d_r    <= 1'b1;
        end
    end

    // ID/EX register: reset/flush insert an all-zero bubble, else load.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_id_ex_flush) begin
            pc_e_r       <= {XLEN{1'b0}};
            pc_plus4_e_r <= {XLEN{1'b0}};
            rd1_e_r      <= {XLEN{1'b0}};
            rd2_e_r      <= {XLEN{1'b0}};
            imm_e_r      <= {XLEN{1'b0}};
            rs1_e_r      <= 5'd0;
            rs2_e_r      <= 5'd0;
            rd_e_r       <= 5'd0;
            ctrl_e_r     <= {CTRL_W{1'b0}};
            valid_e_r    <= 1'b0;
        end else begin
            pc_e_r       <= pc_d_r;
            pc_plus4_e_r <= pc_plus4_d_r;
            rd1_e_r      <= i_rd1_d;
            rd2_e_r      <= i_rd2_d;
            imm_e_r      <= i_imm_d;
            rs1_e_r      <= rs1_d_s;
            rs2_e_r      <= rs2_d_s;
            rd_e_r       <= rd_d_s;
            ctrl_e_r     <= ctrl_gated_s;
            valid_e_r    <= valid_d_r;
        end
    end

    // Saturating counts of PC-stall cycles and IF/ID-flush cycles.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_cnt_r <= 16'd0;
            flush_cnt_r <= 16'd0;
        end else begin
            if (i_pc_stall) begin
                stall_cnt_r <= sat_inc(stall_cnt_r);
            end
            if (i_if_id_flush) begin
                flush_cnt_r <= sat_inc(flush_cnt_r);
            end
        end
    end

    assign o_pc_f       = pc_r;
    assign o_instr_d    = instr_d_r;
    assign o_pc_d       = pc_d_r;
    assign o_pc_plus4_d = pc_plus4_d_r;
    assign o_valid_d    = valid_d_r;
    assign o_rs1_d      = rs1_d_s;
    assign o_rs2_d      = rs2_d_s;
    assign o_rd_d       = rd_d_s;
    assign o_pc_e       = pc_e_r;
    assign o_pc_plus4_e = pc_plus4_e_r;
    assign o_rd1_e      = rd1_e_r;
    assign o_rd2_e      = rd2_e_r;
    assign o_imm_e      = imm_e_r;
    assign o_rs1_e      = rs1_e_r;
    assign o_rs2_e      = rs2_e_r;
    assign o_rd_e       = rd_e_r;
    assign o_ctrl_e     = ctrl_e_r;
    assign o_valid_e    = valid_e_r;
    assign o_stall_cnt  = stall_cnt_r;
    assign o_flush_cnt  = flush_cnt_r;

endmodule

// File: tb/tb_pipe_front_regs.sv
// Directed testbench for pipe_front_regs: reset, free run, load-use bubble,
// branch flush, stall hold, flush-over-stall, counter saturation and reset
// during an active stall.
module tb_pipe_front_regs;

    logic        i_clk = 1'b0;
    logic        i_rst, i_pc_stall, i_if_id_stall, i_if_id_flush, i_id_ex_flush;
    logic [31:0] i_pc_next, i_instr_f, i_rd1_d, i_rd2_d, i_imm_d;
    logic [11:0] i_ctrl_d;
    logic [31:0] o_pc_f, o_instr_d, o_pc_d, o_pc_plus4_d;
    logic        o_valid_d, o_valid_e;
    logic [4:0]  o_rs1_d, o_rs2_d, o_rd_d, o_rs1_e, o_rs2_e, o_rd_e;
    logic [31:0] o_pc_e, o_pc_plus4_e, o_rd1_e, o_rd2_e, o_imm_e;
    logic [11:0] o_ctrl_e;
    logic [15:0] o_stall_cnt, o_flush_cnt;

    logic        redirect_en;
    logic [31:0] redirect_pc;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    // Instruction memory model: fields derived from word index k = pc[6:2].
    function automatic logic [31:0] imem(input logic [31:0] a);
        logic [4:0] k;
        k = a[6:2];
        return {7'h00, k + 5'd2, k + 5'd1, 3'b000, k + 5'd3, 7'h33};
    endfunction

    assign i_pc_next = redirect_en ? redirect_pc : (o_pc_f + 32'd4);
    assign i_instr_f = imem(o_pc_f);

    always #5 i_clk = ~i_clk;

    pipe_front_regs dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_pc_stall(i_pc_stall), .i_if_id_stall(i_if_id_stall),
        .i_if_id_flush(i_if_id_flush), .i_id_ex_flush(i_id_ex_flush),
        .i_pc_next(i_pc_next), .i_instr_f(i_instr_f),
        .i_rd1_d(i_rd1_d), .i_rd2_d(i_rd2_d), .i_imm_d(i_imm_d), .i_ctrl_d(i_ctrl_d),
        .o_pc_f(o_pc_f), .o_instr_d(o_instr_d), .o_pc_d(o_pc_d),
        .o_pc_plus4_d(o_pc_plus4_d), .o_valid_d(o_valid_d),
        .o_rs1_d(o_rs1_d), .o_rs2_d(o_rs2_d), .o_rd_d(o_rd_d),
        .o_pc_e(o_pc_e), .o_pc_plus4_e(o_pc_plus4_e),
        .o_rd1_e(o_rd1_e), .o_rd2_e(o_rd2_e), .o_imm_e(o_imm_e),
        .o_rs1_e(o_rs1_e), .o_rs2_e(o_rs2_e), .o_rd_e(o_rd_e),
        .o_ctrl_e(o_ctrl_e), .o_valid_e(o_valid_e),
        .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt)
    );

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        step();
        step();
        total_cnt++; if (o_pc_f !== 32'h0) $display("FAIL rst_pc got %h want %h", o_pc_f, 32'h0); else pass_cnt++;
        total_cnt++; if (o_instr_d !== NOP) $display("FAIL rst_instr got %h want %h", o_instr_d, NOP); else pass_cnt++;
        total_cnt++; if (o_valid_d !== 1'b0) $display("FAIL rst_valid_d got %b want 0", o_valid_d); else pass_cnt++;
        total_cnt++; if (o_pc_plus4_d !== 32'h0) $display("FAIL rst_pc4_d got %h want 0", o_pc_plus4_d); else pass_cnt++;
        total_cnt++; if ({o_pc_e, o_rd1_e, o_ctrl_e, o_rd_e, o_valid_e} !== '0) $display("FAIL rst_idex got %h/%h/%h/%h/%b want 0", o_pc_e, o_rd1_e, o_ctrl_e, o_rd_e, o_valid_e); else pass_cnt++;
        total_cnt++; if ({o_stall_cnt, o_flush_cnt} !== 32'h0) $display("FAIL rst_cnt got %h/%h want 0", o_stall_cnt, o_flush_cnt); else pass_cnt++;
        i_rst = 1'b0;
    endtask

    task automatic test_free_run();
        step();
        total_cnt++; if (o_pc_f !== 32'h4) $display("FAIL run_pc1 got %h want %h", o_pc_f, 32'h4); else pass_cnt++;
        total_cnt++; if (o_instr_d !== imem(32'h0)) $display("FAIL run_instr1 got %h want %h", o_instr_d, imem(32'h0)); else pass_cnt++;
        total_cnt++; if (o_valid_d !== 1'b1) $display("FAIL run_valid_d1 got %b want 1", o_valid_d); else pass_cnt++;
        total_cnt++; if (o_pc_plus4_d !== 32'h4) $display("FAIL run_pc4_d got %h want 4", o_pc_plus4_d); else pass_cnt++;
        total_cnt++; if (o_rd_d !== 5'd3) $display("FAIL run_rd_d got %0d want 3", o_rd_d); else pass_cnt++;
        total_cnt++; if (o_ctrl_e !== 12'h0) $display("FAIL run_ctrl_invalid got %h want 0", o_ctrl_e); else pass_cnt++;
        total_cnt++; if (o_valid_e !== 1'b0) $display("FAIL run_valid_e1 got %b want 0", o_valid_e); else pass_cnt++;
        step();
        total_cnt++; if (o_pc_f !== 32'h8) $display("FAIL run_pc2 got %h want %h", o_pc_f, 32'h8); else pass_cnt++;
        total_cnt++; if (o_instr_d !== imem(32'h4)) $display("FAIL run_instr2 got %h want %h", o_instr_d, imem(32'h4)); else pass_cnt++;
        total_cnt++; if ({o_pc_e, o_pc_plus4_e} !== {32'h0, 32'h4}) $display("FAIL run_pc_e got %h/%h want 0/4", o_pc_e, o_pc_plus4_e); else pass_cnt++;
        total_cnt++; if ({o_rs1_e, o_rs2_e, o_rd_e} !== {5'd1, 5'd2, 5'd3}) $display("FAIL run_regs_e got %0d/%0d/%0d want 1/2/3", o_rs1_e, o_rs2_e, o_rd_e); else pass_cnt++;
        total_cnt++; if ({o_rd1_e, o_rd2_e, o_imm_e} !== {32'h1111_1111, 32'h2222_2222, 32'hFFFF_FFF0}) $display("FAIL run_data_e got %h/%h/%h", o_rd1_e, o_rd2_e, o_imm_e); else pass_cnt++;
        total_cnt++; if ({o_ctrl_e, o_valid_e} !== {12'hABD, 1'b1}) $display("FAIL run_ctrl_e got %h/%b want abd/1", o_ctrl_e, o_valid_e); else pass_cnt++;
    endtask

    task automatic test_load_use();
        i_pc_stall = 1'b1; i_if_id_stall = 1'b1; i_id_ex_flush = 1'b1;
        step();
        i_pc_stall = 1'b0; i_if_id_stall = 1'b0; i_id_ex_flush = 1'b0;
        total_cnt++; if (o_pc_f !== 32'h8) $display("FAIL lu_pc got %h want 8", o_pc_f); else pass_cnt++;
        total_cnt++; if ({o_instr_d, o_pc_d} !== {imem(32'h4), 32'h4}) $display("FAIL lu_ifid got %h/%h want %h/4", o_instr_d, o_pc_d, imem(32'h4)); else pass_cnt++;
        total_cnt++; if ({o_ctrl_e, o_rd_e, o_valid_e} !== '0) $display("FAIL lu_bubble got %h/%0d/%b want 0", o_ctrl_e, o_rd_e, o_valid_e); else pass_cnt++;
        total_cnt++; if (o_stall_cnt !== 16'd1) $display("FAIL lu_stall_cnt got %0d want 1", o_stall_cnt); else pass_cnt++;
        step();
        total_cnt++; if ({o_pc_f, o_instr_d} !== {32'hC, imem(32'h8)}) $display("FAIL lu_resume got %h/%h", o_pc_f, o_instr_d); else pass_cnt++;
        total_cnt++; if ({o_pc_e, o_rd_e, o_ctrl_e, o_valid_e} !== {32'h4, 5'd4, 12'hABD, 1'b1}) $display("FAIL lu_resume_e got %h/%0d/%h/%b", o_pc_e, o_rd_e, o_ctrl_e, o_valid_e); else pass_cnt++;
    endtask

    task automatic test_branch();
        i_if_id_flush = 1'b1; i_id_ex_flush = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h100;
        step();
        i_if_id_flush = 1'b0; i_id_ex_flush = 1'b0; redirect_en = 1'b0;
        total_cnt++; if (o_pc_f !== 32'h100) $display("FAIL br_pc got %h want 100", o_pc_f); else pass_cnt++;
        total_cnt++; if ({o_instr_d, o_pc_d, o_valid_d} !== {NOP, 32'h0, 1'b0}) $display("FAIL br_ifid got %h/%h/%b", o_instr_d, o_pc_d, o_valid_d); else pass_cnt++;
        total_cnt++; if ({o_valid_e, o_ctrl_e} !== '0) $display("FAIL br_valid_e got %b/%h want 0", o_valid_e, o_ctrl_e); else pass_cnt++;
        total_cnt++; if (o_flush_cnt !== 16'd1) $display("FAIL br_flush_cnt got %0d want 1", o_flush_cnt); else pass_cnt++;
        step();
        total_cnt++; if ({o_pc_f, o_instr_d, o_valid_d} !== {32'h104, imem(32'h100), 1'b1}) $display("FAIL br_target got %h/%h/%b", o_pc_f, o_instr_d, o_valid_d); else pass_cnt++;
        total_cnt++; if ({o_ctrl_e, o_valid_e, o_rd_e} !== '0) $display("FAIL br_invalid_ctrl got %h/%b/%0d want 0", o_ctrl_e, o_valid_e, o_rd_e); else pass_cnt++;
    endtask

    task automatic test_stall_hold();
        i_if_id_stall = 1'b1;
        step();
        i_if_id_stall = 1'b0;
        total_cnt++; if (o_pc_f !== 32'h108) $display("FAIL sh_pc got %h want 108", o_pc_f); else pass_cnt++;
        total_cnt++; if ({o_instr_d, o_pc_plus4_d, o_valid_d} !== {imem(32'h100), 32'h104, 1'b1}) $display("FAIL sh_hold got %h/%h/%b", o_instr_d, o_pc_plus4_d, o_valid_d); else pass_cnt++;
    endtask

    task automatic test_flush_over_stall();
        i_if_id_flush = 1'b1; i_if_id_stall = 1'b1;
        step();
        i_if_id_flush = 1'b0; i_if_id_stall = 1'b0;
        total_cnt++; if ({o_instr_d, o_pc_d, o_valid_d} !== {NOP, 32'h0, 1'b0}) $display("FAIL fos_ifid got %h/%h/%b want NOP", o_instr_d, o_pc_d, o_valid_d); else pass_cnt++;
        total_cnt++; if (o_flush_cnt !== 16'd2) $display("FAIL fos_flush_cnt got %0d want 2", o_flush_cnt); else pass_cnt++;
        total_cnt++; if (o_pc_f !== 32'h10C) $display("FAIL fos_pc got %h want 10c", o_pc_f); else pass_cnt++;
    endtask

    task automatic test_saturate();
        i_pc_stall = 1'b1;
        repeat (65533) step();
        total_cnt++; if (o_stall_cnt !== 16'hFFFE) $display("FAIL sat_pre got %h want fffe", o_stall_cnt); else pass_cnt++;
        step();
        total_cnt++; if (o_stall_cnt !== 16'hFFFF) $display("FAIL sat_hit got %h want ffff", o_stall_cnt); else pass_cnt++;
        repeat (70000 - 65534) step();
        total_cnt++; if (o_stall_cnt !== 16'hFFFF) $display("FAIL sat_hold got %h want ffff", o_stall_cnt); else pass_cnt++;
        total_cnt++; if (o_pc_f !== 32'h10C) $display("FAIL sat_pc got %h want 10c", o_pc_f); else pass_cnt++;
    endtask

    task automatic test_reset_mid_stall();
        i_if_id_stall = 1'b1; i_if_id_flush = 1'b1; i_rst = 1'b1;
        step();
        i_rst = 1'b0; i_pc_stall = 1'b0; i_if_id_stall = 1'b0; i_if_id_flush = 1'b0;
        total_cnt++; if (o_pc_f !== 32'h0) $display("FAIL rms_pc got %h want 0", o_pc_f); else pass_cnt++;
        total_cnt++; if ({o_instr_d, o_valid_d} !== {NOP, 1'b0}) $display("FAIL rms_ifid got %h/%b", o_instr_d, o_valid_d); else pass_cnt++;
        total_cnt++; if ({o_pc_e, o_pc_plus4_e, o_rd1_e, o_rd2_e, o_imm_e, o_rs1_e, o_rs2_e, o_rd_e, o_ctrl_e, o_valid_e} !== '0) $display("FAIL rms_idex got %h/%h/%h/%h/%h/%h", o_pc_e, o_pc_plus4_e, o_rd1_e, o_rd2_e, o_imm_e, o_ctrl_e); else pass_cnt++;
        total_cnt++; if ({o_stall_cnt, o_flush_cnt} !== 32'h0) $display("FAIL rms_cnt got %h/%h want 0", o_stall_cnt, o_flush_cnt); else pass_cnt++;
        step();
        total_cnt++; if ({o_pc_f, o_instr_d, o_valid_d} !== {32'h4, imem(32'h0), 1'b1}) $display("FAIL rms_load got %h/%h/%b", o_pc_f, o_instr_d, o_valid_d); else pass_cnt++;
        total_cnt++; if (o_stall_cnt !== 16'd0) $display("FAIL rms_stall_cnt got %0d want 0", o_stall_cnt); else pass_cnt++;
    endtask

    // Test sequence.
    initial begin
        i_rst = 1'b1; i_pc_stall = 1'b0; i_if_id_stall = 1'b0;
        i_if_id_flush = 1'b0; i_id_ex_flush = 1'b0;
        redirect_en = 1'b0; redirect_pc = 32'h0;
        i_rd1_d = 32'h1111_1111; i_rd2_d = 32'h2222_2222; i_imm_d = 32'hFFFF_FFF0;
        i_ctrl_d = 12'hABD;
        test_reset();
        test_free_run();
        test_load_use();
        test_branch();
        test_stall_hold();
        test_flush_over_stall();
        test_saturate();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
